// File: rtl/serial_acc_ctrl.sv
// rtl/serial_acc_ctrl.sv - sequencer and bit-serial ALU feeding the 8-bit shift accumulator
// Optional sticky signed-overflow flag o_ovf is built only when SACC_OVF_EN is defined.
module serial_acc_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_operand,
    input  logic         i_acc_bit,
    output logic         o_con_shift,
    output logic         o_con_sign,
    output logic         o_data_in,
    output logic         o_data_sign,
    output logic         o_done
`ifdef SACC_OVF_EN
    ,
    output logic         o_ovf
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;
    localparam logic [CW-1:0] LAST_K = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_op;
    logic [W-1:0]   r_operand;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic           r_sign;

    logic           w_b;
    logic           w_sum;
    logic           w_carry_nxt;
    logic           w_last;

    // Operand is consumed LSB-first; SUB adds the inverted operand with carry-in 1.
    assign w_b         = (r_op == OP_SUB) ? ~r_operand[0] : r_operand[0];
    assign w_sum       = i_acc_bit ^ w_b ^ r_carry;
    assign w_carry_nxt = (i_acc_bit & w_b) | (i_acc_bit & r_carry) | (w_b & r_carry);
    assign w_last      = (r_op == OP_ASR) || (r_cnt == LAST_K);

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_con_shift = 1'b0;
        o_con_sign  = 1'b0;
        o_done      = 1'b0;
        o_data_in   = (r_op == OP_CLR) ? 1'b0 : w_sum;
        o_data_sign = r_sign;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_con_shift = 1'b1;
                o_con_sign  = (r_op == OP_ASR);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_operand <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_valid) begin
                r_op      <= i_op;
                r_operand <= i_operand;
                r_carry   <= (i_op == OP_SUB);
                r_cnt     <= '0;
            end else if (r_state == S_RUN && r_op != OP_ASR) begin
                r_operand <= r_operand >> 1;
                r_carry   <= w_carry_nxt;
                r_cnt     <= r_cnt + 1'b1;
                // The final serial bit lands in the accumulator MSB; mirror it as the sign.
                if (w_last) begin
                    r_sign <= o_data_in;
                end
            end
        end
    end

`ifdef SACC_OVF_EN
    // On the MSB cycle r_carry is the carry into the MSB and w_carry_nxt the carry out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last && (r_op == OP_ADD || r_op == OP_SUB)) begin
            if (r_carry != w_carry_nxt) begin
                o_ovf <= 1'b1;
            end
        end else if (r_state == S_DONE && r_op == OP_CLR) begin
            o_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_acc_ctrl.sv
// tb/tb_serial_acc_ctrl.sv - directed bench for serial_acc_ctrl driving an 8-bit shift accumulator model
module tb_serial_acc_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand = '0;
    logic         ready, con_shift, con_sign, data_in, data_sign, done;
    logic [W-1:0] acc;
`ifdef SACC_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_acc_ctrl #(.W(W), .CW(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_op        (op),
        .i_operand   (operand),
        .i_acc_bit   (acc[0]),
        .o_con_shift (con_shift),
        .o_con_sign  (con_sign),
        .o_data_in   (data_in),
        .o_data_sign (data_sign),
        .o_done      (done)
`ifdef SACC_OVF_EN
        ,
        .o_ovf       (ovf)
`endif
    );

    // Accumulator model: shifts right, new MSB from data_in or the sign input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (con_shift) begin
            acc <= {(con_sign ? data_sign : data_in), acc[W-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to o_done; latency counts cycles after the accept edge.
    task automatic run_cmd(input string tag, input logic [1:0] c_op, input logic [W-1:0] c_opnd,
                           input int exp_lat, input logic exp_sign_sel, input logic [W-1:0] exp_acc);
        int n;
        int shifts;
        logic saw_sign;
        @(negedge clk);
        chk({tag, " ready_before"}, ready, 1'b1);
        op = c_op;
        operand = c_opnd;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        n = 0;
        shifts = 0;
        saw_sign = 1'b0;
        while (!done && n < 20) begin
            if (con_shift) shifts++;
            if (con_sign) saw_sign = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " shifts"}, shifts, exp_lat);
        chk({tag, " con_sign"}, saw_sign, exp_sign_sel);
        chk({tag, " done_shift"}, con_shift, 1'b0);
        chk({tag, " acc"}, acc, exp_acc);
        @(posedge clk);
        #1;
        chk({tag, " ready_after"}, ready, 1'b1);
        chk({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int ready_low;
        int dones;

        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", ready, 1'b1);
        chk("rst shift", con_shift, 1'b0);
        chk("rst con_sign", con_sign, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst data_sign", data_sign, 1'b0);
`ifdef SACC_OVF_EN
        chk("rst ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_cmd("clr1", 2'b10, 8'h00, W, 1'b0, 8'h00);
        run_cmd("add5", 2'b00, 8'h05, W, 1'b0, 8'h05);
        run_cmd("add3", 2'b00, 8'h03, W, 1'b0, 8'h08);

        run_cmd("clr2", 2'b10, 8'hAA, W, 1'b0, 8'h00);
        run_cmd("add3b", 2'b00, 8'h03, W, 1'b0, 8'h03);
        run_cmd("sub5", 2'b01, 8'h05, W, 1'b0, 8'hFE);
        chk("sub5 sign", data_sign, 1'b1);

        run_cmd("asr1", 2'b11, 8'h00, 1, 1'b1, 8'hFF);
        chk("asr1 sign", data_sign, 1'b1);
        run_cmd("asr2", 2'b11, 8'h00, 1, 1'b1, 8'hFF);

        // i_valid held high while busy: one ADD 1 executes (0xFF+1 wraps to 0).
        @(negedge clk);
        op = 2'b00;
        operand = 8'h01;
        valid = 1'b1;
        @(posedge clk);
        #1;
        ready_low = 0;
        dones = 0;
        n = 0;
        while (!ready && n < 30) begin
            ready_low++;
            if (done) dones++;
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        valid = 1'b0;
        chk("hold ready_low", ready_low, W + 1);
        chk("hold dones", dones, 1);
        chk("hold acc", acc, 8'h00);
        chk("hold sign", data_sign, 1'b0);
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || con_shift) dones++;
        end
        chk("hold no_second", dones, 0);
        chk("hold acc_stable", acc, 8'h00);

        // Reset during RUN cycle k=3 of an ADD.
        run_cmd("add8", 2'b00, 8'h08, W, 1'b0, 8'h08);
        @(negedge clk);
        op = 2'b00;
        operand = 8'h55;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid shifting", con_shift, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid shift", con_shift, 1'b0);
        chk("rstmid ready", ready, 1'b1);
        chk("rstmid acc", acc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run_cmd("add7", 2'b00, 8'h07, W, 1'b0, 8'h07);

`ifdef SACC_OVF_EN
        run_cmd("oclr", 2'b10, 8'h00, W, 1'b0, 8'h00);
        chk("ovf clr0", ovf, 1'b0);
        run_cmd("oadd100a", 2'b00, 8'd100, W, 1'b0, 8'd100);
        chk("ovf first", ovf, 1'b0);
        run_cmd("oadd100b", 2'b00, 8'd100, W, 1'b0, 8'hC8);
        chk("ovf set", ovf, 1'b1);
        run_cmd("oasr", 2'b11, 8'h00, 1, 1'b1, 8'hE4);
        chk("ovf asr", ovf, 1'b1);
        run_cmd("oclr2", 2'b10, 8'h00, W, 1'b0, 8'h00);
        chk("ovf cleared", ovf, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
